// File: rtl/sync_up_down_counter_mod_if.sv
// Control/status bundle for sync_up_down_counter_mod.
// master drives the controls; slave is the counter and drives the status.
interface sync_up_down_counter_mod_if #(
   parameter int N = 4
);
   // No valid/ready pair: en, sel, load and d are sampled on every rising clk
   // edge and always take effect, so the counter can never stall the driver.
   logic         en;
   logic         sel;
   logic         load;
   logic [N-1:0] d;
   logic [N-1:0] Q;
   logic         tc;
   logic         wrap;

   modport master (
      output en,
      output sel,
      output load,
      output d,
      input  Q,
      input  tc,
      input  wrap
   );

   modport slave (
      input  en,
      input  sel,
      input  load,
      input  d,
      output Q,
      output tc,
      output wrap
   );
endinterface

// File: rtl/sync_up_down_counter_mod.sv
// Fully synchronous modulo-MOD up/down counter with enable, clamped parallel
// load, terminal count and wrap pulse. Define COUNTER_SATURATE_EN to saturate instead of wrapping.
module sync_up_down_counter_mod #(
   parameter int N         = 4,
   parameter int MOD       = 16,
   parameter int RESET_VAL = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   sync_up_down_counter_mod_if.slave bus
);
   // Modulus held at N+1 bits so that MOD = 2^N is representable.
   localparam logic [N:0]   MOD_X = (N+1)'(MOD);
   localparam logic [N-1:0] MAX_Q = N'(MOD - 1);
   localparam logic [N-1:0] RST_Q = N'(RESET_VAL);
   localparam logic [N-1:0] ONE_Q = N'(1);

   logic [N-1:0] q_r;
   logic [N-1:0] q_nxt;
   logic [N-1:0] load_val;
   logic         wrap_r;
   logic         wrap_nxt;
   logic         at_top;
   logic         at_bot;

   assign at_top   = (q_r == MAX_Q);
   assign at_bot   = (q_r == '0);
   assign load_val = ({1'b0, bus.d} < MOD_X) ? bus.d : MAX_Q;

   always_comb begin
      q_nxt    = q_r;
      wrap_nxt = 1'b0;
      if (bus.load) begin
         q_nxt = load_val;
      end else if (bus.en) begin
         if (bus.sel) begin
            if (at_top) begin
`ifdef COUNTER_SATURATE_EN
               q_nxt = q_r;
`else
               q_nxt    = '0;
               wrap_nxt = 1'b1;
`endif
            end else begin
               q_nxt = q_r + ONE_Q;
            end
         end else begin
            if (at_bot) begin
`ifdef COUNTER_SATURATE_EN
               q_nxt = q_r;
`else
               q_nxt    = MAX_Q;
               wrap_nxt = 1'b1;
`endif
            end else begin
               q_nxt = q_r - ONE_Q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r    <= RST_Q;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
      end
   end

   // tc looks at the current state only, so a pending load does not mask it.
   assign bus.Q    = q_r;
   assign bus.wrap = wrap_r;
   assign bus.tc   = bus.en & ((bus.sel & at_top) | (~bus.sel & at_bot));
endmodule

// File: tb/tb_sync_up_down_counter_mod.sv
// Directed bench for sync_up_down_counter_mod: MOD=10 and MOD=16 instances,
// wrap and saturate builds selected by COUNTER_SATURATE_EN.
module tb_sync_up_down_counter_mod;
   localparam int N = 4;
`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sync_up_down_counter_mod_if #(.N(N)) bus10 ();
   sync_up_down_counter_mod_if #(.N(N)) bus16 ();

   sync_up_down_counter_mod #(.N(N), .MOD(10), .RESET_VAL(0)) dut10 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus10.slave)
   );

   sync_up_down_counter_mod #(.N(N), .MOD(16), .RESET_VAL(0)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16.slave)
   );

   // scoreboard
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [N-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // reference behaviour of one enabled step
   function automatic int nxt(input int q, input bit up, input int m);
      if (up) return (q == m - 1) ? (SAT ? q : 0) : q + 1;
      else    return (q == 0) ? (SAT ? q : m - 1) : q - 1;
   endfunction

   function automatic bit wr(input int q, input bit up, input int m);
      return !SAT && (up ? (q == m - 1) : (q == 0));
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count10(input string tag, input bit up, input int steps, inout int q);
      bus10.en   = 1'b1;
      bus10.sel  = up;
      bus10.load = 1'b0;
      for (int i = 0; i < steps; i++) begin
         #1;
         check({tag, "_tc"}, 32'(bus10.tc), 32'(up ? (q == 9) : (q == 0)));
         exp_q.push_back(N'(nxt(q, up, 10)));
         tick();
         check({tag, "_q"}, 32'(bus10.Q), 32'(exp_q.pop_front()));
         check({tag, "_wrap"}, 32'(bus10.wrap), 32'(wr(q, up, 10)));
         q = nxt(q, up, 10);
      end
   endtask

   task automatic load10(input logic [N-1:0] val);
      bus10.load = 1'b1;
      bus10.d    = val;
      tick();
      bus10.load = 1'b0;
   endtask

   initial begin
      int q;
      reset      = 1'b1;
      bus10.en   = 1'b0; bus10.sel = 1'b0; bus10.load = 1'b0; bus10.d = '0;
      bus16.en   = 1'b0; bus16.sel = 1'b0; bus16.load = 1'b0; bus16.d = '0;
      tick();
      check("rst_q10", 32'(bus10.Q), 32'd0);
      check("rst_wrap10", 32'(bus10.wrap), 32'd0);
      check("rst_q16", 32'(bus16.Q), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // count to 6, then reset between edges
      bus10.en = 1'b1; bus10.sel = 1'b1;
      repeat (6) tick();
      check("pre_rst_q", 32'(bus10.Q), 32'd6);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_q", 32'(bus10.Q), 32'd0);
      check("mid_rst_wrap", 32'(bus10.wrap), 32'd0);
      bus10.en = 1'b0;
      #1 reset = 1'b0;
      tick(); tick();
      check("rst_hold_q", 32'(bus10.Q), 32'd0);

      // up sweep through the wrap, then down through the wrap
      q = 0;
      count10("up", 1'b1, 10, q);
      count10("down", 1'b0, 3, q);

      // load priority and clamp
      bus10.en = 1'b0;
      load10(4'd3);
      check("load3_q", 32'(bus10.Q), 32'd3);
      bus10.en = 1'b1; bus10.sel = 1'b1;
      load10(4'd7);
      check("load7_q", 32'(bus10.Q), 32'd7);
      load10(4'd12);
      check("clamp_q", 32'(bus10.Q), 32'd9);
      bus10.load = 1'b1; bus10.d = 4'd9;
      #1;
      check("tc_under_load", 32'(bus10.tc), 32'd1);
      tick();
      bus10.load = 1'b0;
      check("load_at_top_q", 32'(bus10.Q), 32'd9);
      check("load_at_top_wrap", 32'(bus10.wrap), 32'd0);
      bus10.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_q", 32'(bus10.Q), 32'd9);
         check("hold_tc", 32'(bus10.tc), 32'd0);
      end

      // direction change mid-count
      load10(4'd4);
      bus10.en = 1'b1; bus10.sel = 1'b1;
      tick();
      check("dir_up_q", 32'(bus10.Q), 32'd5);
      bus10.sel = 1'b0;
      tick();
      check("dir_down_q", 32'(bus10.Q), 32'd4);
      tick();
      check("dir_down2_q", 32'(bus10.Q), 32'd3);

      // terminal behaviour from 8 upward and from 1 downward
      bus10.en = 1'b0;
      load10(4'd8);
      q = 8;
      count10("top", 1'b1, 3, q);
      bus10.en = 1'b0;
      load10(4'd1);
      q = 1;
      count10("bot", 1'b0, 2, q);
      bus10.en = 1'b0;

      // power-of-two modulus instance
      bus16.load = 1'b1; bus16.d = 4'd15;
      tick();
      check("m16_load15_q", 32'(bus16.Q), 32'd15);
      bus16.d = 4'd14;
      tick();
      bus16.load = 1'b0;
      bus16.en = 1'b1; bus16.sel = 1'b1;
      tick();
      check("m16_q15", 32'(bus16.Q), 32'd15);
      check("m16_tc", 32'(bus16.tc), 32'd1);
      check("m16_wrap_pre", 32'(bus16.wrap), 32'd0);
      tick();
      check("m16_q_wrap", 32'(bus16.Q), 32'(nxt(15, 1'b1, 16)));
      check("m16_wrap", 32'(bus16.wrap), 32'(wr(15, 1'b1, 16)));
      bus16.en = 1'b0;
      tick();
      check("m16_wrap_clear", 32'(bus16.wrap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sync_up_down_counter_mod.md
# sync_up_down_counter_mod

Fully synchronous, parametrised modulo-MOD up/down counter, the successor to the ripple-clocked asynchronous up/down counter. All state flops share a single clock. The block adds count enable, synchronous parallel load, a programmable modulus and terminal-count/wrap flags. It serves as the general-purpose event/timer counter in sequential designs where ripple skew is unacceptable.

## Interface
- N, 4: counter width in bits; N ≥ 1.
- MOD, 16: count modulus; legal range 2 ≤ MOD ≤ 2^N; the count range is 0..MOD-1.
- RESET_VAL, 0: value Q takes on reset; must be < MOD.

- clk  input  1  the single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; high = advance by one step per clock.
- sel  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load; takes priority over en.
- d  input  N  load value.
- Q  output  N  current count, registered.
- tc  output  1  terminal count, combinational from Q, sel and en.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap-around.

## Operation
- Priority at each rising clk edge: reset > load > en > hold.
- reset high, at any time and asynchronously, including mid-count: Q = RESET_VAL and wrap = 0 immediately. Both hold until the first edge after reset deasserts.
- load = 1: Q ← d when d < MOD. When d ≥ MOD, Q ← MOD-1 (clamp). wrap ← 0. en and sel are ignored.
- en = 1, load = 0, sel = 1: Q ← Q+1 when Q < MOD-1. When Q = MOD-1, Q ← 0 and wrap ← 1.
- en = 1, load = 0, sel = 0: Q ← Q-1 when Q > 0. When Q = 0, Q ← MOD-1 and wrap ← 1.
- en = 0, load = 0: Q holds and wrap ← 0.
- wrap is 0 in every cycle not immediately following a wrap-around.
- tc = en & ((sel & Q == MOD-1) | (~sel & Q == 0)). It asserts in the same cycle as the state that will wrap on the next edge. load does not mask tc.
- Arithmetic: next-state compares are done at N+1 bits so that MOD = 2^N works. The MOD-1 constant is N bits. Q never leaves 0..MOD-1.
- Direction change (sel toggled with en = 1) takes effect on the next edge, with no lost or extra step.

## Timing
- Count latency: 1 clock from en/sel/load sampled to new Q.
- tc is combinational, with zero cycles from Q/sel/en. It is glitch-free only after Q settles, so downstream logic samples it on clk.
- wrap: 1-cycle registered pulse coinciding with the first cycle Q shows the wrapped value (0 for up, MOD-1 for down).
- Reset: asynchronous assertion. Deassertion must meet recovery/removal to clk; the user synchronises it upstream.
- No combinational path from d or load to any output.

## Configuration
- COUNTER_SATURATE_EN
  - Defined: saturating mode. At Q = MOD-1 counting up, or at Q = 0 counting down, Q holds instead of wrapping. wrap is tied to 0, and tc is still asserted at the terminal state. load and reset behave as above.
  - Undefined (default): wrap-around behaviour as in Operation.

## Test plan
- Reset: N=4, MOD=10, RESET_VAL=0, count to Q=6, then pulse reset mid-cycle -> Q=0 and wrap=0 immediately, with no clock edge needed; Q holds 0 with en=0.
- Up wrap: en=1, sel=1 from Q=0 for 10 edges -> Q steps 1..9 then 0; tc=1 only while Q=9; wrap=1 only in the cycle Q returns to 0.
- Down wrap: en=1, sel=0 from Q=0 -> next Q=9 with wrap=1; tc=1 while Q=0; the following edges give 8, 7 with wrap=0.
- Load/priority: at Q=3 with en=1, load=1, d=7 -> Q=7. Then d=12 with load=1 -> Q=9 (clamp). Then en=0, load=0 for 3 edges -> Q stays 9.
- Direction change and MOD=2^N: with MOD=10, at Q=5 toggle sel 1→0 -> Q=4 next edge. With N=4, MOD=16, up from 15 -> Q=0 and wrap=1.
- Saturate build (COUNTER_SATURATE_EN defined, MOD=10): up from 8 -> 9, 9, 9 with tc=1 and wrap=0. Down from 1 -> 0, 0 with wrap=0.
